// File: rtl/div_pkg.sv
// div_pkg: shared constants, funct3 codes and FSM state type for the RV32M divide unit
//   XLEN/CNT_W sizing, INST_* funct3 codes, ZeroWord/ZeroReg, ready levels, state_t
package div_pkg;
   localparam int XLEN = 32;
   localparam int CNT_W = 6;
   localparam logic [2:0] INST_DIV = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;
   localparam logic [XLEN-1:0] ZeroWord = '0;
   localparam logic [4:0] ZeroReg = '0;
   localparam logic DivResultReady = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_END = 2'd2
   } state_t;
endpackage

// File: rtl/div_if.sv
// div_if: request/result bundle between execute (master) and the divide unit (slave)
//   start_i/op_i/dividend_i/divisor_i/reg_waddr_i: request, driven by master
//   result_o/ready_o/busy_o/reg_waddr_o: completion and stall, driven by slave
interface div_if;
   import div_pkg::*;
   logic start_i;
   logic [2:0] op_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic [4:0] reg_waddr_i;
   logic [XLEN-1:0] result_o;
   logic ready_o;
   logic busy_o;
   logic [4:0] reg_waddr_o;
   modport master (
      output start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
      input result_o, ready_o, busy_o, reg_waddr_o
   );
   modport slave (
      input start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
      output result_o, ready_o, busy_o, reg_waddr_o
   );
endinterface

// File: rtl/div.sv
// div: multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock
//   clk, rst (sync, active-high); bus: div_if.slave request/result bundle
module div
   import div_pkg::*;
(
   input logic clk,
   input logic rst,
   div_if.slave bus
);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [1:0] op_q;
   logic [4:0] rd_q;
   logic [XLEN-1:0] dvd, dvs, rem, quo;
   logic neg_q, neg_r;
   logic accept, sgn, dz_in, borrow;
   logic [XLEN-1:0] a_abs, b_abs, diff, res;
   logic [XLEN:0] shifted;
   assign accept = bus.start_i && bus.op_i[2];
   assign sgn = !bus.op_i[0];
   assign dz_in = bus.divisor_i == ZeroWord;
   assign a_abs = (sgn && bus.dividend_i[XLEN-1]) ? -bus.dividend_i : bus.dividend_i;
   assign b_abs = (sgn && bus.divisor_i[XLEN-1]) ? -bus.divisor_i : bus.divisor_i;
   // partial remainder stays below the divisor, so the low word of the difference is exact when no borrow
   assign shifted = {rem, dvd[XLEN-1]};
   assign borrow = shifted < {1'b0, dvs};
   assign diff = shifted[XLEN-1:0] - dvs;
   // dvs is only zero in END on the divide-by-zero path, where dvd holds the raw dividend
   assign res = (dvs == ZeroWord) ? (op_q[1] ? dvd : '1) :
                op_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   always_ff @(posedge clk) state <= rst ? DIV_IDLE : state_n;
   always_comb begin
      state_n = (state == DIV_IDLE) ? (accept ? (dz_in ? DIV_END : DIV_CALC) : DIV_IDLE) :
                (state == DIV_CALC) ? ((cnt == LastCnt) ? DIV_END : DIV_CALC) : DIV_IDLE;
   end
   always_comb bus.busy_o = state != DIV_IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         op_q <= '0;
         rd_q <= ZeroReg;
         dvd <= ZeroWord;
         dvs <= ZeroWord;
         rem <= ZeroWord;
         quo <= ZeroWord;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         bus.result_o <= ZeroWord;
         bus.ready_o <= DivResultNotReady;
         bus.reg_waddr_o <= ZeroReg;
      end else begin
         bus.ready_o <= DivResultNotReady;
         if (state == DIV_IDLE && accept) begin
            op_q <= bus.op_i[1:0];
            rd_q <= bus.reg_waddr_i;
            dvd <= dz_in ? bus.dividend_i : a_abs;
            dvs <= b_abs;
            neg_q <= sgn && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
            neg_r <= sgn && bus.dividend_i[XLEN-1];
            cnt <= '0;
            quo <= ZeroWord;
            rem <= ZeroWord;
         end else if (state == DIV_CALC) begin
            dvd <= dvd << 1;
            rem <= borrow ? shifted[XLEN-1:0] : diff;
            quo <= {quo[XLEN-2:0], !borrow};
            cnt <= cnt + CNT_W'(1);
         end else if (state == DIV_END) begin
            bus.result_o <= res;
            bus.ready_o <= DivResultReady;
            bus.reg_waddr_o <= rd_q;
         end
      end
   end
endmodule

// File: tb/tb_div.sv
// tb_div: self-checking bench for div, latency/arithmetic reference model plus directed literal checks
module tb_div;
   import div_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   int m_left = 0;
   logic m_ready = 1'b0;
   logic [31:0] m_res = '0, m_pend = '0;
   logic [4:0] m_rd = '0, m_prd = '0;
   logic [31:0] res;
   logic [4:0] rdo;
   int lat, bcnt, pulses;
   div_if bus();
   div u_div (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [31:0] q, r;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction
   function automatic logic [31:0] rnd_word();
      int k = int'($urandom % 6);
      return (k == 0) ? 32'h0 : (k == 1) ? 32'hFFFF_FFFF : (k == 2) ? 32'h8000_0000 :
             (k == 3) ? 32'($urandom_range(0, 20)) : 32'($urandom);
   endfunction
   // reference: an accepted request completes 33 edges later (1 edge on divide by zero)
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            m_left = 0;
            m_ready = 1'b0;
            m_res = '0;
            m_rd = '0;
         end else begin
            m_ready = 1'b0;
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_ready = 1'b1;
                  m_res = m_pend;
                  m_rd = m_prd;
               end
            end else if (bus.start_i && bus.op_i[2]) begin
               m_pend = ref_res(bus.op_i, bus.dividend_i, bus.divisor_i);
               m_prd = bus.reg_waddr_i;
               m_left = (bus.divisor_i == 0) ? 1 : 33;
            end
         end
         chk("busy", 32'(bus.busy_o), 32'(m_left > 0));
         chk("ready", 32'(bus.ready_o), 32'(m_ready));
         chk("result", bus.result_o, m_res);
         chk("waddr", 32'(bus.reg_waddr_o), 32'(m_rd));
      end
   end
   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      input int inj, output logic [31:0] r, output logic [4:0] ro, output int l, output int bc);
      bus.start_i = 1'b1;
      bus.op_i = op;
      bus.dividend_i = a;
      bus.divisor_i = b;
      bus.reg_waddr_i = rd;
      l = -1;
      bc = 0;
      r = '0;
      ro = '0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (n == inj) begin
            bus.start_i = 1'b1;
            bus.op_i = INST_DIVU;
            bus.dividend_i = 32'd50;
            bus.divisor_i = 32'd5;
            bus.reg_waddr_i = 5'd3;
         end
         bc += int'(bus.busy_o);
         if (bus.ready_o) begin
            l = n;
            r = bus.result_o;
            ro = bus.reg_waddr_o;
            break;
         end
      end
   endtask
   initial begin
      bus.start_i = 1'b0;
      bus.op_i = '0;
      bus.dividend_i = '0;
      bus.divisor_i = '0;
      bus.reg_waddr_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_result", bus.result_o, 32'h0);
      chk("rst_ready", 32'(bus.ready_o), 32'h0);
      chk("rst_busy", 32'(bus.busy_o), 32'h0);
      chk("rst_waddr", 32'(bus.reg_waddr_o), 32'h0);
      run(INST_DIVU, 32'd100, 32'd7, 5'd5, -1, res, rdo, lat, bcnt);
      chk("divu_100_7", res, 32'd14);
      chk("divu_lat", 32'(lat), 32'd33);
      chk("divu_busy_cycles", 32'(bcnt), 32'd33);
      chk("divu_rd", 32'(rdo), 32'd5);
      run(INST_REMU, 32'd100, 32'd7, 5'd6, -1, res, rdo, lat, bcnt);
      chk("remu_100_7", res, 32'd2);
      run(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, -1, res, rdo, lat, bcnt);
      chk("div_m7_2", res, 32'hFFFF_FFFD);
      run(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, -1, res, rdo, lat, bcnt);
      chk("rem_m7_2", res, 32'hFFFF_FFFF);
      run(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, res, rdo, lat, bcnt);
      chk("div_ovf", res, 32'h8000_0000);
      run(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, res, rdo, lat, bcnt);
      chk("rem_ovf", res, 32'h0);
      run(INST_DIVU, 32'd5, 32'd0, 5'd9, -1, res, rdo, lat, bcnt);
      chk("divu_dz", res, 32'hFFFF_FFFF);
      chk("divu_dz_lat", 32'(lat), 32'd1);
      chk("divu_dz_rd", 32'(rdo), 32'd9);
      run(INST_REM, 32'hFFFF_FFFB, 32'd0, 5'd10, -1, res, rdo, lat, bcnt);
      chk("rem_dz", res, 32'hFFFF_FFFB);
      chk("rem_dz_lat", 32'(lat), 32'd1);
      run(INST_DIVU, 32'd100, 32'd7, 5'd11, 5, res, rdo, lat, bcnt);
      chk("busy_start_res", res, 32'd14);
      chk("busy_start_rd", 32'(rdo), 32'd11);
      run(INST_DIVU, 32'd9, 32'd3, 5'd12, -1, res, rdo, lat, bcnt);
      chk("chain_res", res, 32'd3);
      chk("chain_lat", 32'(lat), 32'd33);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i = 3'b000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nonm_busy", 32'(bus.busy_o), 32'h0);
         chk("nonm_ready", 32'(bus.ready_o), 32'h0);
      end
      bus.start_i = 1'b1;
      bus.op_i = INST_DIVU;
      bus.dividend_i = 32'd1000;
      bus.divisor_i = 32'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy_o), 32'h0);
      chk("abort_ready", 32'(bus.ready_o), 32'h0);
      chk("abort_result", bus.result_o, 32'h0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         pulses += int'(bus.ready_o);
      end
      chk("abort_no_pulse", 32'(pulses), 32'h0);
      run(INST_DIVU, 32'd81, 32'd9, 5'd13, -1, res, rdo, lat, bcnt);
      chk("after_abort", res, 32'd9);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom % 400) == 0;
         bus.start_i = ($urandom % 3) == 0;
         bus.op_i = {($urandom % 8) != 0, 2'($urandom)};
         bus.dividend_i = rnd_word();
         bus.divisor_i = rnd_word();
         bus.reg_waddr_i = 5'($urandom);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.start_i = 1'b0;
      repeat (40) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle RV32M divide/remainder unit serving DIV, DIVU, REM and REMU.
- The decode stage issues these instructions with register write disabled and the PC+4 resume target. Execute stalls on them, hands the operands to this block, and writes rd back when ready_o pulses.
- Algorithm: restoring division, one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dividend_i  in  32  rs1 value.
- divisor_i  in  32  rs2 value.
- reg_waddr_i  in  5  destination rd.
- result_o  out  32  quotient or remainder; held until next completion.
- ready_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high while an operation is in flight; execute holds the pipeline on it.
- reg_waddr_o  out  5  rd captured at start; valid with ready_o.

Behaviour:
- Clock and reset: one clock. rst is synchronous and active-high (clk/rst as elsewhere in the design).
- Reset values: state = IDLE, result_o = 0, ready_o = 0, reg_waddr_o = 0, counter = 0, internal registers = 0. busy_o = 0.
- busy_o is combinational: (state != IDLE).
- States: IDLE, CALC, END.

IDLE:
- Accepts only when start_i = 1 and op_i[2] = 1. Any other op_i value is ignored and the state stays IDLE.
- On the accept edge (E0):
  - Capture op_i and reg_waddr_i.
  - Capture |dividend| and |divisor|; absolute values are taken only for signed ops (DIV, REM).
  - Capture the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Clear the counter, quotient and partial remainder.
- Next state after E0: END if divisor_i == 0, else CALC.

CALC, edges E1..E32, one iteration per edge:
- Shift {rem, dividend} left by 1.
- Trial-subtract the divisor.
- If no borrow, keep the difference and set quotient bit = 1; else quotient bit = 0.
- Counter increments each edge; at count 31 the next state is END.

END, one edge:
- Normal case:
  - DIV/DIVU: result_o = quotient, negated if the quotient sign is set (signed ops only).
  - REM/REMU: result_o = remainder, negated if the remainder sign is set (signed only).
- Divide by zero:
  - Quotient = 0xFFFFFFFF for both signed and unsigned.
  - Remainder = original dividend, unmodified.
- Signed overflow 0x80000000 / -1 falls out naturally: quotient 0x80000000, remainder 0. No special path.
- ready_o = 1 for exactly one cycle; reg_waddr_o updated together with result_o; next state = IDLE.

Latency:
- Normal: ready_o is visible after edge E33, i.e. 33 edges after the accept edge.
- Divide by zero: ready_o is visible after E1.
- busy_o is high from after E0 until the edge that raises ready_o.

Boundary conditions:
- start_i while busy: ignored. Operands are not re-captured and the in-flight result is unaffected.
- start_i in the same cycle ready_o is high: accepted (state is IDLE); ready_o drops on that edge.
- rst mid-operation: abort on the next edge. All outputs return to their reset values; no ready_o pulse is produced.
- result_o and reg_waddr_o are stable between completions.

Decomposition:
- The shared defines header holds:
  - funct3 codes INST_DIV/INST_DIVU/INST_REM/INST_REMU;
  - ZeroWord and ZeroReg;
  - the state encodings as named constants (DIV_IDLE, DIV_CALC, DIV_END);
  - the DivResultReady/DivResultNotReady level constants.
- No sub-module: the iteration datapath is a single 33-bit subtractor and fits inline.

Test Plan:
1. DIVU, 100 / 7:
   - ready_o after 33 edges; result_o = 14.
   - Repeat as REMU: result_o = 2.
   - busy_o high for exactly 33 cycles.
2. DIV, 0xFFFFFFF9 / 2: result_o = 0xFFFFFFFD. REM, same operands: result_o = 0xFFFFFFFF.
3. DIV, 0x80000000 / 0xFFFFFFFF: result_o = 0x80000000. REM, same operands: result_o = 0.
4. Divide by zero:
   - DIVU 5 / 0: ready_o after 1 edge, result_o = 0xFFFFFFFF.
   - REM 0xFFFFFFFB / 0: result_o = 0xFFFFFFFB.
   - reg_waddr_o = captured rd.
5. Handshake corners:
   - Second start at cycle 5 with different operands: ignored; first result (DIVU 100/7 = 14) returned.
   - Start asserted in the ready_o cycle (DIVU 9/3): accepted, result_o = 3 after a further 33 edges.
   - op_i = 000 with start_i = 1: no busy_o, no ready_o.
6. rst high for one cycle at CALC iteration 10:
   - busy_o = 0, ready_o = 0, result_o = 0 on the next cycle; no stray ready_o pulse afterwards.
   - A following DIVU 81 / 9 returns 9.
